// File: rtl/video_timing_pkg.sv
// Shared raster timing defaults, window bounds and text cell geometry
// for the video scan generator.
package video_timing_pkg;

  localparam int H_ACTIVE_D   = 800;
  localparam int H_FP_D       = 40;
  localparam int H_SYNC_D     = 128;
  localparam int H_BP_D       = 88;
  localparam int V_ACTIVE_D   = 600;
  localparam int V_FP_D       = 1;
  localparam int V_SYNC_D     = 4;
  localparam int V_BP_D       = 23;
  localparam int SYNC_DELAY_D = 2;

  localparam int WIN_V_START   = 108;
  localparam int WIN_V_END     = 491;
  localparam int WIN_G_H_START = 68;
  localparam int WIN_G_H_END   = 731;
  localparam int WIN_T_H_START = 144;
  localparam int WIN_T_H_END   = 655;

  localparam int CELL_W    = 16;
  localparam int CELL_H    = 24;
  localparam int TEXT_COLS = 32;
  localparam int TEXT_ROWS = 16;

  localparam int LINE_A84_STEP = 84;

  typedef enum logic {
    MODE_TEXT  = 1'b0,
    MODE_GRAPH = 1'b1
  } win_mode_e;

  function automatic logic in_range(
    input logic [31:0] x,
    input int          lo,
    input int          hi
  );
    return (x >= 32'(lo)) && (x <= 32'(hi));
  endfunction

endpackage

// File: rtl/video_scan_gen_if.sv
// Scan generator bundle: mode select in, timing and
// window indices out.
interface video_scan_gen_if;

  logic        ag;
  logic        hsync;
  logic        vsync;
  logic        show_border;
  logic        video_on;
  logic        frame_start;
  logic [6:0]  char_column;
  logic [6:0]  char_line;
  logic [3:0]  subchar_pixel;
  logic [4:0]  subchar_line;
  logic [9:0]  graph_pixel;
  logic [9:0]  graph_line_2x;
  logic [9:0]  graph_line_3x;
  logic [13:0] graph_line_a84;

  modport master (
    input  ag,
    output hsync, vsync, show_border, video_on,
    output frame_start, char_column, char_line,
    output subchar_pixel, subchar_line, graph_pixel,
    output graph_line_2x, graph_line_3x, graph_line_a84
  );

  modport slave (
    output ag,
    input  hsync, vsync, show_border, video_on,
    input  frame_start, char_column, char_line,
    input  subchar_pixel, subchar_line, graph_pixel,
    input  graph_line_2x, graph_line_3x, graph_line_a84
  );

endinterface

// File: rtl/video_scan_gen_scan_counter.sv
// Wrap counter 0..MAX with enable and a terminal-count flag
// that is high while the count sits at MAX.
module scan_counter #(
  parameter int MAX = 1055,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = (r_cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_max ? '0 : r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = w_at_max;

endmodule

// File: rtl/video_scan_gen.sv
// Raster scan generator: h/v counters, delayed syncs and text or
// graphics window indices, all registered one clock behind h/v.
module video_scan_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_D,
  parameter int H_FP       = H_FP_D,
  parameter int H_SYNC     = H_SYNC_D,
  parameter int H_BP       = H_BP_D,
  parameter int V_ACTIVE   = V_ACTIVE_D,
  parameter int V_FP       = V_FP_D,
  parameter int V_SYNC     = V_SYNC_D,
  parameter int V_BP       = V_BP_D,
  parameter int SYNC_DELAY = SYNC_DELAY_D
) (
  input  logic             pixel_clock,
  input  logic             reset,
  video_scan_gen_if.master vif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;

  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  logic          w_h_tc;
  logic          w_v_tc;

  scan_counter #(.MAX(H_TOTAL - 1), .W(HW)) u_h_cnt (
    .clk  (pixel_clock),
    .rst  (reset),
    .i_en (1'b1),
    .o_cnt(w_h),
    .o_tc (w_h_tc)
  );

  scan_counter #(.MAX(V_TOTAL - 1), .W(VW)) u_v_cnt (
    .clk  (pixel_clock),
    .rst  (reset),
    .i_en (w_h_tc),
    .o_cnt(w_v),
    .o_tc (w_v_tc)
  );

  logic [31:0] w_hx, w_vx, w_hs, w_he;
  logic        w_in_v, w_win, w_active, w_text;
  logic        w_hs_raw, w_vs_raw;
  logic [9:0]  w_gp;
  win_mode_e   r_mode;

  assign w_hx = 32'(w_h);
  assign w_vx = 32'(w_v);

  assign w_hs = (r_mode == MODE_GRAPH) ?
                32'(WIN_G_H_START) : 32'(WIN_T_H_START);
  assign w_he = (r_mode == MODE_GRAPH) ?
                32'(WIN_G_H_END) : 32'(WIN_T_H_END);

  assign w_in_v   = in_range(w_vx, WIN_V_START, WIN_V_END);
  assign w_win    = w_in_v && in_range(w_hx, w_hs, w_he);
  assign w_active = (w_hx < 32'(H_ACTIVE)) && (w_vx < 32'(V_ACTIVE));
  assign w_text   = w_win && (r_mode == MODE_TEXT);
  assign w_gp     = 10'(w_hx - w_hs);

  assign w_hs_raw = in_range(w_hx, HS_START, HS_START + H_SYNC - 1);
  assign w_vs_raw = in_range(w_vx, VS_START, VS_START + V_SYNC - 1);

  // Mode is sampled only at line end so a mid-line change waits a line.
  always_ff @(posedge pixel_clock) begin
    if (reset || w_h_tc) begin
      r_mode <= win_mode_e'(vif.ag);
    end
  end

  logic [9:0]  r_l2x, r_l3x;
  logic [1:0]  r_m3;
  logic [13:0] r_a84;
  logic [4:0]  r_sl;
  logic [3:0]  r_cl;
  logic        w_top;

  assign w_top = w_h_tc && (w_v_tc || w_vx == 32'(WIN_V_START - 1));

  always_ff @(posedge pixel_clock) begin
    if (reset || w_top) begin
      r_l2x <= '0;
      r_l3x <= '0;
      r_m3  <= '0;
      r_a84 <= '0;
      r_sl  <= '0;
      r_cl  <= '0;
    end else if (w_h_tc && w_in_v) begin
      r_l2x <= r_l2x + 10'd1;
      if (r_m3 == 2'd2) begin
        r_m3  <= '0;
        r_l3x <= r_l3x + 10'd1;
      end else begin
        r_m3 <= r_m3 + 2'd1;
      end
      if (r_l2x[0]) begin
        r_a84 <= r_a84 + 14'(LINE_A84_STEP);
      end
      if (r_sl == 5'(CELL_H - 1)) begin
        r_sl <= '0;
        r_cl <= r_cl + 4'd1;
      end else begin
        r_sl <= r_sl + 5'd1;
      end
    end
  end

  logic [SYNC_DELAY-1:0] r_hs_sr, r_vs_sr;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_hs_sr <= '0;
      r_vs_sr <= '0;
    end else begin
      r_hs_sr[0] <= w_hs_raw;
      r_vs_sr[0] <= w_vs_raw;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        r_hs_sr[i] <= r_hs_sr[i-1];
        r_vs_sr[i] <= r_vs_sr[i-1];
      end
    end
  end

  logic        r_bd, r_von, r_fs;
  logic [9:0]  r_gp, r_o2x, r_o3x;
  logic [13:0] r_oa84;
  logic [3:0]  r_sp;
  logic [4:0]  r_osl;
  logic [6:0]  r_cc, r_ocl;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_bd   <= 1'b1;
      r_von  <= 1'b0;
      r_fs   <= 1'b0;
      r_gp   <= '0;
      r_o2x  <= '0;
      r_o3x  <= '0;
      r_oa84 <= '0;
      r_sp   <= '0;
      r_osl  <= '0;
      r_cc   <= '0;
      r_ocl  <= '0;
    end else begin
      r_bd   <= !(w_win && w_active);
      r_von  <= w_active;
      r_fs   <= (w_h == '0) && (w_v == '0);
      r_gp   <= w_win ? w_gp : '0;
      r_o2x  <= w_win ? r_l2x : '0;
      r_o3x  <= w_win ? r_l3x : '0;
      r_oa84 <= w_win ? r_a84 : '0;
      r_sp   <= w_text ? w_gp[3:0] : '0;
      r_cc   <= w_text ? {2'b00, w_gp[8:4]} : '0;
      r_osl  <= w_text ? r_sl : '0;
      r_ocl  <= w_text ? {3'b000, r_cl} : '0;
    end
  end

  assign vif.hsync          = r_hs_sr[SYNC_DELAY-1];
  assign vif.vsync          = r_vs_sr[SYNC_DELAY-1];
  assign vif.show_border    = r_bd;
  assign vif.video_on       = r_von;
  assign vif.frame_start    = r_fs;
  assign vif.graph_pixel    = r_gp;
  assign vif.graph_line_2x  = r_o2x;
  assign vif.graph_line_3x  = r_o3x;
  assign vif.graph_line_a84 = r_oa84;
  assign vif.subchar_pixel  = r_sp;
  assign vif.char_column    = r_cc;
  assign vif.subchar_line   = r_osl;
  assign vif.char_line      = r_ocl;

endmodule

// File: doc/video_scan_gen.md
VIDEO_SCAN_GEN -- requirements
Module: video_scan_gen

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 The module SHALL have parameter H_FP / H_SYNC / H_BP, defaults 40 / 128 / 88, horizontal porch and sync widths in pixels (total 1056).
REQ-003 The module SHALL have parameter V_ACTIVE, default 600, visible lines per frame.
REQ-004 The module SHALL have parameter V_FP / V_SYNC / V_BP, defaults 1 / 4 / 23, vertical porch and sync widths in lines (total 628).
REQ-005 The module SHALL have parameter SYNC_DELAY, default 2, extra cycles applied to hsync/vsync to match the downstream pixel pipeline.
REQ-006 The module SHALL have these ports:
- pixel_clock  in  1  pixel clock, 40 MHz.
- reset  in  1  synchronous, active-high.
- ag  in  1  0 = text window, 1 = graphics window.
- hsync, vsync  out  1 each  positive-polarity sync, delayed by SYNC_DELAY.
- show_border  out  1  high outside the active window or during blanking.
- video_on  out  1  high inside the H_ACTIVE × V_ACTIVE region.
- char_column  out  7  text column, 0..31.
- char_line  out  7  text row, 0..15.
- subchar_pixel  out  4  pixel within a cell, 0..15.
- subchar_line  out  5  line within a cell, 0..23.
- graph_pixel  out  10  pixel index from window left edge, 0..window width-1.
- graph_line_2x  out  10  line index from window top edge, 0..383.
- graph_line_3x  out  10  window line divided by 3, 0..127.
- graph_line_a84  out  14  (graph_line_2x>>1)*84.
- frame_start  out  1  one-cycle pulse at h=0, v=0.

Function
REQ-007 h_cnt SHALL count 0..1055 and wrap to 0. v_cnt SHALL advance when h_cnt wraps, counting 0..627 and wrapping to 0.
REQ-008 Active sync SHALL be:
- hsync raw high for h_cnt in [840, 967].
- vsync raw high for v_cnt in [601, 604].
- Both SHALL pass through a SYNC_DELAY-deep shift register.
REQ-009 The window SHALL be:
- Vertical, both modes: v_cnt in [108, 491].
- Horizontal, ag=1: h_cnt in [68, 731] (664 px).
- Horizontal, ag=0: h_cnt in [144, 655] (512 px).
REQ-010 All outputs except hsync/vsync SHALL be registered, with 1-cycle latency from h_cnt/v_cnt, and SHALL be mutually aligned.
REQ-011 graph_pixel SHALL be 0 on the first window pixel, increment by 1 per clock inside the window, and hold 0 outside it.
REQ-012 In the text window:
- subchar_pixel SHALL equal graph_pixel[3:0].
- char_column SHALL equal graph_pixel[8:4].
- subchar_line SHALL cycle 0..23, then char_line SHALL increment.
- All four SHALL be 0 outside the window.
REQ-013 graph_line_2x SHALL be 0 on the first window line, increment once per window line, and be 0 outside the window.
REQ-014 graph_line_3x SHALL increment every third window line, using a mod-3 sub-counter reset at the window top.
REQ-015 graph_line_a84 SHALL be an accumulator:
- Cleared at the window top.
- Incremented by 84 at the end of each odd window line (graph_line_2x[0]=1).
- No multiplier SHALL be used.
- Maximum value 191*84=16044, which fits in 14 bits.
REQ-016 A change of ag mid-frame SHALL take effect on the next line. Line counters SHALL be unaffected.
REQ-017 show_border SHALL equal NOT(in window AND video_on).

Reset
REQ-018 On reset:
- h_cnt=0, v_cnt=0.
- hsync=vsync=0, and the sync shift register SHALL be cleared.
- show_border=1, video_on=0, frame_start=0.
- All index outputs SHALL be 0.
REQ-019 On the first cycle after reset deassertion, frame_start SHALL pulse.
REQ-020 Reset asserted mid-line SHALL restart timing from h=0, v=0 on the next edge.

Structure
REQ-021 Timing defaults and window bounds SHALL live in a shared package, video_timing_pkg, together with the text cell constants (16 × 24, 32 × 16).
REQ-022 The block SHALL contain one sub-module, scan_counter (a parameterised wrap counter with a terminal-count output), instantiated for h and v.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset release, then 1056×628 clocks: exactly one frame_start, 628 hsync pulses of 128 clocks each, one vsync pulse of 4 lines.
- ag=1, line v=108: graph_pixel=0 at the output for h=68 (+1 latency), and 663 at h=731. show_border=0 across the window and 1 at h=732.
- ag=1, v=491: graph_line_2x=383, graph_line_a84=16044, graph_line_3x=127. At v=492, all three are 0 and show_border=1.
- ag=0, v=108+24: char_line=1 and subchar_line=0. At h=144+16, char_column=1 and subchar_pixel=0.
- SYNC_DELAY=2: hsync rises exactly 2 clocks after raw h_cnt=840.
- Reset asserted at h=500, v=300 for 1 clock: next-cycle outputs match the post-reset state, and frame_start pulses.
